// File: rtl/matrix_pkg.sv
// Shared types and widths for the matrix load controller.
// Holds datapath widths, bank count, FSM state type and a bank decode helper.
package matrix_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 16;
    localparam int NBANK     = 16;
    localparam int BANK_W    = 4;
    localparam int IDX_W     = BANK_W + ADDR_W;
    localparam int MAX_ELEMS = NBANK * (2 ** ADDR_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bank number to one-hot select / write-enable vector.
    function automatic logic [NBANK-1:0] bank_onehot(
        input logic [BANK_W-1:0] b
    );
        logic [NBANK-1:0] v;
        v    = '0;
        v[b] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/matrix_load_ctl_if.sv
// Bundle between the element source / datapath and the load controller.
// Ports: start/abort control, s_* element stream, ram_sel/a/din/we RAM
// write port, busy/done/err status. slave = controller view.
interface matrix_load_ctl_if;
    import matrix_pkg::*;

    logic              start;
    logic              abort;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic [NBANK-1:0]  ram_sel;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] din;
    logic [NBANK-1:0]  we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, abort, s_valid, s_data, s_last,
        input  s_ready, ram_sel, a, din, we, busy, done, err
    );

    modport slave (
        input  start, abort, s_valid, s_data, s_last,
        output s_ready, ram_sel, a, din, we, busy, done, err
    );

endinterface

// File: rtl/matrix_idx_ctr.sv
// Element index counter: bank in the top bits, row address below.
// Ports: CLK, RST_L, clr, inc in; idx (20 bits), tc (idx at last element) out.
module matrix_idx_ctr
    import matrix_pkg::*;
#(
    parameter int TOTAL = 1024 * 1024
) (
    input  logic             CLK,
    input  logic             RST_L,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(TOTAL - 1);

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign tc = (idx == LAST);

endmodule

// File: rtl/matrix_load_ctl.sv
// Streams a row-major matrix into 16 banked RAMs, one element per cycle.
// Ports: CLK, RST_L (sync, active-low), bus (slave modport of the bundle).
module matrix_load_ctl
    import matrix_pkg::*;
#(
    parameter int ROWS = 1024,
    parameter int COLS = 1024
) (
    input  logic                CLK,
    input  logic                RST_L,
    matrix_load_ctl_if.slave    bus
);

    localparam int TOTAL = ROWS * COLS;

    if (TOTAL < 1 || TOTAL > MAX_ELEMS) begin : g_size_chk
        $error("matrix_load_ctl: ROWS*COLS out of range");
    end

    state_t            state;
    state_t            state_nxt;
    logic              clr;
    logic              fire;
    logic              wr;
    logic              tc;
    logic [IDX_W-1:0]  idx;

    logic [NBANK-1:0]  we_q;
    logic [NBANK-1:0]  sel_q;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] din_q;
    logic              err_q;

    assign fire = bus.s_valid && (state == ST_LOAD);
    // A beat taken in the abort cycle is dropped, not written.
    assign wr   = fire && !bus.abort;

    matrix_idx_ctr #(
        .TOTAL (TOTAL)
    ) u_idx (
        .CLK   (CLK),
        .RST_L (RST_L),
        .clr   (clr),
        .inc   (wr),
        .idx   (idx),
        .tc    (tc)
    );

    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_nxt = ST_LOAD;
                    clr       = 1'b1;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_nxt = ST_IDLE;
                end else if (fire && tc) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write port is registered; address/data/select hold between beats.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            we_q  <= '0;
            sel_q <= '0;
            a_q   <= '0;
            din_q <= '0;
        end else if (wr) begin
            we_q  <= bank_onehot(idx[IDX_W-1:ADDR_W]);
            sel_q <= bank_onehot(idx[IDX_W-1:ADDR_W]);
            a_q   <= idx[ADDR_W-1:0];
            din_q <= bus.s_data;
        end else begin
            we_q  <= '0;
        end
    end

    // Framing error: s_last must coincide exactly with the final element.
    always_ff @(posedge CLK) begin
        if (!RST_L) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if (wr && (bus.s_last != tc)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.s_ready = (state == ST_LOAD);
    assign bus.busy    = (state == ST_LOAD);
    assign bus.done    = (state == ST_DONE);
    assign bus.err     = err_q;
    assign bus.we      = we_q;
    assign bus.ram_sel = sel_q;
    assign bus.a       = a_q;
    assign bus.din     = din_q;

endmodule

// File: tb/tb_matrix_load_ctl.sv
// Bench for matrix_load_ctl: 4x4 instance against a count-based model,
// plus a 1x65540 instance for the bank-crossing stream.
module tb_matrix_load_ctl;

    localparam int TOT  = 16;
    localparam int BTOT = 65540;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    matrix_load_ctl_if sb ();
    matrix_load_ctl_if bb ();

    matrix_load_ctl #(.ROWS(4), .COLS(4)) dut (
        .CLK   (clk),
        .RST_L (rst_l),
        .bus   (sb.slave)
    );

    matrix_load_ctl #(.ROWS(1), .COLS(BTOT)) dut_big (
        .CLK   (clk),
        .RST_L (rst_l),
        .bus   (bb.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: phase flags plus count of elements accepted so far.
    bit          m_load, m_dn, m_err;
    int          m_cnt;
    logic [15:0] m_we, m_sel, m_a;
    logic [31:0] m_din;

    typedef struct {
        bit          st, ab, v, l, rs;
        logic [31:0] d;
        logic [15:0] we, a;
        bit          busy, done, err;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic cyc(input bit st, input bit ab, input bit v,
                       input logic [31:0] d, input bit l, input bit rs);
        sb.start   = st;
        sb.abort   = ab;
        sb.s_valid = v;
        sb.s_data  = d;
        sb.s_last  = l;
        rst_l      = rs;
        m_we = '0;
        if (!rs) begin
            m_load = 0; m_dn = 0; m_err = 0; m_cnt = 0;
            m_sel = '0; m_a = '0; m_din = '0;
        end else if (m_load) begin
            if (ab) begin
                m_load = 0;
            end else if (v) begin
                m_we  = 16'(1) << (m_cnt / 65536);
                m_sel = m_we;
                m_a   = 16'(m_cnt % 65536);
                m_din = d;
                if (l != (m_cnt == TOT - 1)) m_err = 1;
                if (m_cnt == TOT - 1) begin
                    m_load = 0;
                    m_dn   = 1;
                end
                m_cnt++;
            end
        end else if (m_dn) begin
            m_dn = 0;
        end else if (st && !ab) begin
            m_load = 1; m_cnt = 0; m_err = 0;
        end
        @(posedge clk);
        #1;
        chk("we",      sb.we,      m_we);
        chk("ram_sel", sb.ram_sel, m_sel);
        chk("a",       sb.a,       m_a);
        chk("din",     sb.din,     m_din);
        chk("busy",    sb.busy,    m_load);
        chk("s_ready", sb.s_ready, m_load);
        chk("done",    sb.done,    m_dn);
        chk("err",     sb.err,     m_err);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        bit          v, l, st, ab, rs;
        int          bad, wcnt;
        logic [15:0] ew;

        bb.start = 0; bb.abort = 0; bb.s_valid = 0;
        bb.s_data = 0; bb.s_last = 0;

        //  st ab v  l  rs d      we a    busy done err
        tbl[0]  = '{0,0,0,0,0, 32'h0,  16'h0, 16'h0, 0,0,0};
        tbl[1]  = '{1,0,0,0,1, 32'h0,  16'h0, 16'h0, 1,0,0};
        tbl[2]  = '{0,0,1,0,1, 32'hAA, 16'h1, 16'h0, 1,0,0};
        tbl[3]  = '{0,0,0,0,1, 32'h0,  16'h0, 16'h0, 1,0,0};
        tbl[4]  = '{0,0,1,1,1, 32'hBB, 16'h1, 16'h1, 1,0,1};
        tbl[5]  = '{1,0,0,0,1, 32'h0,  16'h0, 16'h1, 1,0,1};
        tbl[6]  = '{0,1,1,0,1, 32'hCC, 16'h0, 16'h1, 0,0,1};
        tbl[7]  = '{0,0,0,0,1, 32'h0,  16'h0, 16'h1, 0,0,1};
        tbl[8]  = '{1,1,0,0,1, 32'h0,  16'h0, 16'h1, 0,0,1};
        tbl[9]  = '{1,0,0,0,1, 32'h0,  16'h0, 16'h1, 1,0,0};
        tbl[10] = '{0,0,0,0,0, 32'h0,  16'h0, 16'h0, 0,0,0};

        for (int i = 0; i < 11; i++) begin
            cyc(tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].d,
                tbl[i].l, tbl[i].rs);
            chk($sformatf("tbl%0d_we", i),   sb.we,   tbl[i].we);
            chk($sformatf("tbl%0d_a", i),    sb.a,    tbl[i].a);
            chk($sformatf("tbl%0d_busy", i), sb.busy, tbl[i].busy);
            chk($sformatf("tbl%0d_done", i), sb.done, tbl[i].done);
            chk($sformatf("tbl%0d_err", i),  sb.err,  tbl[i].err);
        end

        // Clean 4x4 load, values 0..15.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < TOT; i++) cyc(0, 0, 1, i, i == TOT - 1, 1);
        chk("clean_done_now", sb.done, 1);
        chk("clean_last_a", sb.a, 15);
        idle(2);
        chk("clean_err", sb.err, 0);

        // Early s_last on beat 8; load still completes.
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < TOT; i++) cyc(0, 0, 1, i + 100, i == 7, 1);
        chk("early_done", sb.done, 1);
        chk("early_err", sb.err, 1);
        idle(2);
        chk("early_err_sticky", sb.err, 1);

        // Abort carried with beat 5.
        cyc(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, i, 0, 1);
        cyc(0, 1, 1, 4, 0, 1);
        chk("abort_no_write", sb.we, 0);
        chk("abort_a_held", sb.a, 3);
        idle(3);
        cyc(1, 0, 0, 0, 0, 1);
        cyc(0, 0, 1, 32'h55, 0, 1);
        chk("restart_a0", sb.a, 0);

        // Reset mid-load.
        cyc(0, 0, 1, 32'h66, 0, 1);
        cyc(0, 0, 1, 32'h77, 0, 0);
        chk("rst_we", sb.we, 0);
        chk("rst_busy", sb.busy, 0);
        cyc(0, 0, 1, 32'h88, 0, 1);
        chk("rst_no_resume", sb.we, 0);

        // Random stream with gaps, starts, rare aborts and resets.
        for (int i = 0; i < 600; i++) begin
            v  = $urandom_range(0, 2) != 0;
            st = $urandom_range(0, 3) == 0;
            ab = $urandom_range(0, 29) == 0;
            rs = $urandom_range(0, 149) != 0;
            l  = (m_cnt == TOT - 1);
            if ($urandom_range(0, 11) == 0) l = !l;
            cyc(st, ab, v, $urandom, l, rs);
        end
        cyc(0, 0, 0, 0, 0, 0);
        idle(1);

        // Bank crossing on the long instance.
        bad = 0;
        wcnt = 0;
        bb.start = 1;
        @(posedge clk); #1;
        bb.start = 0;
        bb.s_valid = 1;
        for (int k = 0; k < BTOT; k++) begin
            bb.s_data = k;
            bb.s_last = (k == BTOT - 1);
            @(posedge clk); #1;
            ew = 16'(1) << (k / 65536);
            if (bb.we != 0) wcnt++;
            if (bb.we !== ew || bb.ram_sel !== ew ||
                bb.a !== 16'(k % 65536) || bb.din !== k)
                bad++;
            if (k == 65535) begin
                chk("big_a_ffff", bb.a, 16'hFFFF);
                chk("big_we_b0", bb.we, 16'h0001);
            end
            if (k == 65536) begin
                chk("big_a_wrap", bb.a, 16'h0000);
                chk("big_we_b1", bb.we, 16'h0002);
                chk("big_sel_b1", bb.ram_sel, 16'h0002);
            end
        end
        chk("big_final_a", bb.a, 16'h0003);
        chk("big_done", bb.done, 1);
        chk("big_ready_low", bb.s_ready, 0);
        chk("big_err", bb.err, 0);
        bb.s_valid = 0;
        bb.s_last = 0;
        @(posedge clk); #1;
        chk("big_done_once", bb.done, 0);
        chk("big_we_idle", bb.we, 0);
        chk("big_sel_kept", bb.ram_sel, 16'h0002);
        chk("big_stream_bad", bad, 0);
        chk("big_writes", wcnt, BTOT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
